rtc_ctrl: RTL and testbench

- Sequencing controller for the calendar counter (sec/min/hour/day/month/year).
- Generates the counter's advance enable from a clock prescaler.
- Accepts host "set time" requests over a valid/ready handshake, range-checks them (including days-in-month and leap year), and issues a single-cycle load to the counter.
- Guarantees that a load and an advance never occur in the same cycle.

---
 rtl/rtc_pkg.sv | 40 ++++
 rtl/rtc_prescaler.sv | 49 ++++
 rtl/rtc_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_rtc_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC sequencing controller.
//   - Calendar field widths and range limits
//   - Controller state enumeration
//   - days_in_month(): days in a month, including the Gregorian leap-year rule
package rtc_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned DAY_W  = 5;
    localparam int unsigned MONT_W = 4;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MONT_W-1:0] MONT_MAX = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        LOAD,
        ERR
    } rtc_state_e;

    // Out-of-range months return 31; the caller rejects them separately.
    function automatic logic [DAY_W-1:0] days_in_month(
        input logic [MONT_W-1:0] mont,
        input logic [31:0]       year
    );
        logic leap;
        leap = (year[1:0] == 2'b00) &&
               (((year % 32'd100) != 32'd0) || ((year % 32'd400) == 32'd0));
        case (mont)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides clk down to the calendar advance tick.
//   clk, rst : clock, synchronous active-high reset
//   hold     : freeze the count (no tick) while high
//   clear    : restart the count from 0 and suppress this tick; wins over hold
//   tick     : registered one-cycle pulse every TICK_DIV enabled cycles
module rtc_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/rtc_ctrl.sv
// rtc_ctrl: sequencing controller for the calendar counter.
//   - set_valid/set_ready handshake captures a set-time request, which is
//     range-checked (incl. days-in-month / leap year) for one cycle, then
//     either loaded (load + ld_* + set_done) or rejected (set_err).
//   - tick: prescaled advance enable; a load clears the prescaler and
//     suppresses the tick of that cycle, so load and tick never coincide.
//   - Optional alarm (macro RTC_CTRL_ALARM_EN): alm_valid arms an hh:mm
//     alarm; alarm_hit pulses on the rising edge of the cur_* match at :00.
//     Without the macro alarm_hit is 0 and alm_*/cur_* are ignored.
// All outputs are registered.
module rtc_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned YEAR_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [SEC_W-1:0]  set_sec,
    input  logic [MIN_W-1:0]  set_min,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [DAY_W-1:0]  set_day,
    input  logic [MONT_W-1:0] set_mont,
    input  logic [YEAR_W-1:0] set_year,
    output logic              set_done,
    output logic              set_err,
    output logic              tick,
    output logic              load,
    output logic [SEC_W-1:0]  ld_sec,
    output logic [MIN_W-1:0]  ld_min,
    output logic [HOUR_W-1:0] ld_hour,
    output logic [DAY_W-1:0]  ld_day,
    output logic [MONT_W-1:0] ld_mont,
    output logic [YEAR_W-1:0] ld_year,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic              alm_valid,
    input  logic [MIN_W-1:0]  alm_min,
    input  logic [HOUR_W-1:0] alm_hour,
    output logic              alarm_hit
);

    rtc_state_e state_q, state_d;

    logic [SEC_W-1:0]  cap_sec_q,  cap_sec_d;
    logic [MIN_W-1:0]  cap_min_q,  cap_min_d;
    logic [HOUR_W-1:0] cap_hour_q, cap_hour_d;
    logic [DAY_W-1:0]  cap_day_q,  cap_day_d;
    logic [MONT_W-1:0] cap_mont_q, cap_mont_d;
    logic [YEAR_W-1:0] cap_year_q, cap_year_d;

    logic              set_ready_q, set_ready_d;
    logic              load_q, load_d;
    logic              set_err_q, set_err_d;
    logic [SEC_W-1:0]  ld_sec_q,  ld_sec_d;
    logic [MIN_W-1:0]  ld_min_q,  ld_min_d;
    logic [HOUR_W-1:0] ld_hour_q, ld_hour_d;
    logic [DAY_W-1:0]  ld_day_q,  ld_day_d;
    logic [MONT_W-1:0] ld_mont_q, ld_mont_d;
    logic [YEAR_W-1:0] ld_year_q, ld_year_d;

    logic fields_ok;

    always_comb begin
        fields_ok = (cap_sec_q  <= SEC_MAX)  &&
                    (cap_min_q  <= MIN_MAX)  &&
                    (cap_hour_q <= HOUR_MAX) &&
                    (cap_mont_q != '0) && (cap_mont_q <= MONT_MAX) &&
                    (cap_day_q  != '0) &&
                    (cap_day_q  <= days_in_month(cap_mont_q, 32'(cap_year_q)));
    end

    always_comb begin
        state_d    = state_q;
        cap_sec_d  = cap_sec_q;
        cap_min_d  = cap_min_q;
        cap_hour_d = cap_hour_q;
        cap_day_d  = cap_day_q;
        cap_mont_d = cap_mont_q;
        cap_year_d = cap_year_q;

        case (state_q)
            IDLE: begin
                if (set_valid && set_ready_q) begin
                    state_d    = CHECK;
                    cap_sec_d  = set_sec;
                    cap_min_d  = set_min;
                    cap_hour_d = set_hour;
                    cap_day_d  = set_day;
                    cap_mont_d = set_mont;
                    cap_year_d = set_year;
                end
            end
            CHECK:   state_d = fields_ok ? LOAD : ERR;
            LOAD:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // and line up with the state they belong to.
        set_ready_d = (state_d == IDLE);
        load_d      = (state_d == LOAD);
        set_err_d   = (state_d == ERR);
        ld_sec_d    = load_d ? cap_sec_d  : '0;
        ld_min_d    = load_d ? cap_min_d  : '0;
        ld_hour_d   = load_d ? cap_hour_d : '0;
        ld_day_d    = load_d ? cap_day_d  : '0;
        ld_mont_d   = load_d ? cap_mont_d : '0;
        ld_year_d   = load_d ? cap_year_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_sec_q   <= '0;
            cap_min_q   <= '0;
            cap_hour_q  <= '0;
            cap_day_q   <= '0;
            cap_mont_q  <= '0;
            cap_year_q  <= '0;
            set_ready_q <= 1'b1;
            load_q      <= 1'b0;
            set_err_q   <= 1'b0;
            ld_sec_q    <= '0;
            ld_min_q    <= '0;
            ld_hour_q   <= '0;
            ld_day_q    <= '0;
            ld_mont_q   <= '0;
            ld_year_q   <= '0;
        end else begin
            state_q     <= state_d;
            cap_sec_q   <= cap_sec_d;
            cap_min_q   <= cap_min_d;
            cap_hour_q  <= cap_hour_d;
            cap_day_q   <= cap_day_d;
            cap_mont_q  <= cap_mont_d;
            cap_year_q  <= cap_year_d;
            set_ready_q <= set_ready_d;
            load_q      <= load_d;
            set_err_q   <= set_err_d;
            ld_sec_q    <= ld_sec_d;
            ld_min_q    <= ld_min_d;
            ld_hour_q   <= ld_hour_d;
            ld_day_q    <= ld_day_d;
            ld_mont_q   <= ld_mont_d;
            ld_year_q   <= ld_year_d;
        end
    end

    // Clearing on the edge that enters LOAD zeroes the tick of the LOAD
    // cycle (dropped, not deferred) and restarts the count from 0.
    rtc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .clear (load_d),
        .tick  (tick)
    );

    assign set_ready = set_ready_q;
    assign load      = load_q;
    assign set_done  = load_q;
    assign set_err   = set_err_q;
    assign ld_sec    = ld_sec_q;
    assign ld_min    = ld_min_q;
    assign ld_hour   = ld_hour_q;
    assign ld_day    = ld_day_q;
    assign ld_mont   = ld_mont_q;
    assign ld_year   = ld_year_q;

`ifdef RTC_CTRL_ALARM_EN
    logic [MIN_W-1:0]  alm_min_q,  alm_min_d;
    logic [HOUR_W-1:0] alm_hour_q, alm_hour_d;
    logic              armed_q, armed_d;
    logic              seen_q, seen_d;
    logic              alarm_hit_q, alarm_hit_d;
    logic              match_now;

    always_comb begin
        alm_min_d   = alm_min_q;
        alm_hour_d  = alm_hour_q;
        armed_d     = armed_q;
        alarm_hit_d = 1'b0;
        match_now   = armed_q && (cur_hour == alm_hour_q) &&
                      (cur_min == alm_min_q) && (cur_sec == '0);
        seen_d      = match_now;
        if (alm_valid) begin
            alm_min_d  = alm_min;
            alm_hour_d = alm_hour;
            armed_d    = 1'b1;
            // Arming onto an already-true match counts as seen, so only a
            // later rising edge fires.
            seen_d     = (cur_hour == alm_hour) && (cur_min == alm_min) &&
                         (cur_sec == '0);
        end else begin
            alarm_hit_d = match_now && !seen_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alm_min_q   <= '0;
            alm_hour_q  <= '0;
            armed_q     <= 1'b0;
            seen_q      <= 1'b0;
            alarm_hit_q <= 1'b0;
        end else begin
            alm_min_q   <= alm_min_d;
            alm_hour_q  <= alm_hour_d;
            armed_q     <= armed_d;
            seen_q      <= seen_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign alarm_hit = alarm_hit_q;
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = ^{alm_valid, alm_min, alm_hour,
                                   cur_sec, cur_min, cur_hour};
    assign alarm_hit = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_ctrl.sv
// tb_rtc_ctrl: self-checking bench for rtc_ctrl (TICK_DIV=4, YEAR_W=13).
// Directed requests from the test plan followed by randomized traffic,
// all compared cycle by cycle against a calendar-rule reference model.
module tb_rtc_ctrl;

    localparam int unsigned TDIV = 4;
    localparam int unsigned YW   = 13;

    logic          clk = 1'b0;
    logic          rst, hold, set_valid;
    logic          set_ready, set_done, set_err, tick, load, alarm_hit;
    logic [5:0]    set_sec, set_min, ld_sec, ld_min, cur_sec, cur_min, alm_min;
    logic [4:0]    set_hour, set_day, ld_hour, ld_day, cur_hour, alm_hour;
    logic [3:0]    set_mont, ld_mont;
    logic [YW-1:0] set_year, ld_year;
    logic          alm_valid;

    always #5 clk = ~clk;

    rtc_ctrl #(
        .TICK_DIV (TDIV),
        .YEAR_W   (YW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_sec   (set_sec),
        .set_min   (set_min),
        .set_hour  (set_hour),
        .set_day   (set_day),
        .set_mont  (set_mont),
        .set_year  (set_year),
        .set_done  (set_done),
        .set_err   (set_err),
        .tick      (tick),
        .load      (load),
        .ld_sec    (ld_sec),
        .ld_min    (ld_min),
        .ld_hour   (ld_hour),
        .ld_day    (ld_day),
        .ld_mont   (ld_mont),
        .ld_year   (ld_year),
        .cur_sec   (cur_sec),
        .cur_min   (cur_min),
        .cur_hour  (cur_hour),
        .alm_valid (alm_valid),
        .alm_min   (alm_min),
        .alm_hour  (alm_hour),
        .alarm_hit (alarm_hit)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            cyc     = 0;
    int            acc_cyc = -1;
    int            en_cnt  = 0;
    bit            acc_ok, m_acc, after_rst;
    bit            e_ready = 1'b1, e_tick, e_load, e_err, e_hit;
    logic [5:0]    a_sec, a_min;
    logic [4:0]    a_hour, a_day;
    logic [3:0]    a_mont;
    logic [YW-1:0] a_year;
    bit            al_armed;
    int            al_min, al_hour;
    int            p_sec, p_min, p_hour;

    function automatic bit req_ok(int s, int mi, int h, int d, int mo, int y);
        int dim [13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        int lim;
        if (s > 59 || mi > 59 || h > 23 || mo < 1 || mo > 12) return 1'b0;
        lim = dim[mo];
        if (mo == 2 && ((y % 4 == 0 && y % 100 != 0) || y % 400 == 0)) lim = 29;
        return (d >= 1) && (d <= lim);
    endfunction

    function automatic bit at_alarm(int h, int mi, int s);
        return al_armed && h == al_hour && mi == al_min && s == 0;
    endfunction

    // Advance the model over the clock edge just taken, using the inputs
    // that were applied before that edge.
    task automatic model_update();
        cyc++;
        m_acc = 1'b0;
        if (rst) begin
            acc_cyc = -1; en_cnt = 0; after_rst = 1'b1;
            e_ready = 1'b1; e_tick = 1'b0; e_load = 1'b0; e_err = 1'b0;
            e_hit = 1'b0; al_armed = 1'b0; al_min = 0; al_hour = 0;
        end else begin
            after_rst = 1'b0;
            e_load = 1'b0;
            e_err  = 1'b0;
            if (acc_cyc >= 0 && cyc == acc_cyc + 1) begin
                e_load = acc_ok;
                e_err  = !acc_ok;
            end
            if (set_valid && e_ready) begin
                m_acc   = 1'b1;
                acc_cyc = cyc;
                a_sec = set_sec; a_min = set_min; a_hour = set_hour;
                a_day = set_day; a_mont = set_mont; a_year = set_year;
                acc_ok = req_ok(int'(set_sec), int'(set_min), int'(set_hour),
                                int'(set_day), int'(set_mont), int'(set_year));
            end
            e_ready = (acc_cyc < 0) || (cyc >= acc_cyc + 2);
            if (e_load) begin
                en_cnt = 0;
                e_tick = 1'b0;
            end else if (!hold) begin
                en_cnt++;
                e_tick = (en_cnt % TDIV) == 0;
            end else begin
                e_tick = 1'b0;
            end
`ifdef RTC_CTRL_ALARM_EN
            if (alm_valid) begin
                al_armed = 1'b1;
                al_min   = int'(alm_min);
                al_hour  = int'(alm_hour);
                e_hit    = 1'b0;
            end else begin
                e_hit = at_alarm(int'(cur_hour), int'(cur_min), int'(cur_sec)) &&
                        !at_alarm(p_hour, p_min, p_sec);
            end
`else
            e_hit = 1'b0;
`endif
        end
        p_sec = int'(cur_sec); p_min = int'(cur_min); p_hour = int'(cur_hour);
    endtask

    task automatic compare_all();
        check_eq("set_ready", 32'(set_ready), 32'(e_ready));
        check_eq("tick",      32'(tick),      32'(e_tick));
        check_eq("load",      32'(load),      32'(e_load));
        check_eq("set_done",  32'(set_done),  32'(e_load));
        check_eq("set_err",   32'(set_err),   32'(e_err));
        check_eq("alarm_hit", 32'(alarm_hit), 32'(e_hit));
        if (e_load) begin
            check_eq("ld_sec",  32'(ld_sec),  32'(a_sec));
            check_eq("ld_min",  32'(ld_min),  32'(a_min));
            check_eq("ld_hour", 32'(ld_hour), 32'(a_hour));
            check_eq("ld_day",  32'(ld_day),  32'(a_day));
            check_eq("ld_mont", 32'(ld_mont), 32'(a_mont));
            check_eq("ld_year", 32'(ld_year), 32'(a_year));
        end
        if (after_rst) begin
            check_eq("rst_ld", 32'({ld_sec, ld_min, ld_hour, ld_day, ld_mont}), 32'd0);
            check_eq("rst_ld_year", 32'(ld_year), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        compare_all();
    endtask

    task automatic send(input int s, input int mi, input int h,
                        input int d, input int mo, input int y);
        int n = 0;
        set_valid = 1'b1;
        set_sec = 6'(s); set_min = 6'(mi); set_hour = 5'(h);
        set_day = 5'(d); set_mont = 4'(mo); set_year = YW'(y);
        do begin
            step();
            n++;
        end while (!m_acc && n < 10);
        set_valid = 1'b0;
        if (!m_acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: no handshake within %0d cycles", n);
        end
    endtask

    task automatic rand_req();
        int sel;
        set_sec  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
        set_min  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
        set_hour = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
        set_mont = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 12));
        set_day  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(27, 31)) : 5'($urandom_range(0, 31));
        sel = $urandom_range(0, 6);
        case (sel)
            0: set_year = YW'(1900);
            1: set_year = YW'(2000);
            2: set_year = YW'(2023);
            3: set_year = YW'(2024);
            4: set_year = YW'(2100);
            5: set_year = YW'(2400);
            default: set_year = YW'($urandom_range(0, 8191));
        endcase
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; set_valid = 1'b0;
        set_sec = '0; set_min = '0; set_hour = '0; set_day = '0;
        set_mont = '0; set_year = '0;
        alm_valid = 1'b0; alm_min = '0; alm_hour = '0;
        cur_sec = '0; cur_min = '0; cur_hour = '0;

        step();
        step();
        rst = 1'b0;
        repeat (13) step();

        // Leap day load, then watch the restarted prescaler.
        send(58, 59, 23, 29, 2, 2024);
        repeat (8) step();

        // Calendar boundaries.
        send(0, 0, 0, 29, 2, 1900);  repeat (2) step();
        send(0, 0, 0, 29, 2, 2000);  repeat (2) step();
        send(0, 0, 0, 31, 4, 2023);  repeat (2) step();
        send(0, 0, 24, 1, 1, 2023);  repeat (2) step();
        send(59, 59, 23, 31, 12, 2023);
        send(60, 0, 0, 1, 1, 2023);
        send(0, 0, 0, 0, 1, 2023);
        send(0, 0, 0, 1, 13, 2023);
        send(0, 0, 0, 1, 0, 2023);
        send(0, 0, 0, 28, 2, 2023);
        send(0, 0, 0, 29, 2, 2023);
        repeat (3) step();

        // Load landing on a scheduled tick.
        for (int i = 0; i < int'(TDIV) && ((en_cnt + 2) % TDIV) != 0; i++) step();
        send(1, 2, 3, 4, 5, 2025);
        repeat (6) step();

        // Reset during the check cycle discards the request.
        send(10, 10, 10, 10, 10, 2010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();

        // Hold does not block a load.
        hold = 1'b1;
        send(5, 6, 7, 8, 9, 2030);
        repeat (3) step();
        hold = 1'b0;
        repeat (3) step();

        // Alarm: rising edge fires once; arming onto a live match does not.
        alm_valid = 1'b1; alm_hour = 5'd7; alm_min = 6'd30;
        cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
        step();
        alm_valid = 1'b0;
        step();
        cur_min = 6'd30; cur_sec = 6'd0;
        repeat (4) step();
        cur_min = 6'd31;
        step();
        alm_valid = 1'b1; alm_min = 6'd31;
        step();
        alm_valid = 1'b0;
        repeat (3) step();

        // Randomized traffic.
        repeat (600) begin
            rst  = ($urandom_range(0, 99) == 0);
            hold = ($urandom_range(0, 9) < 2);
            if (!set_valid || m_acc) begin
                set_valid = ($urandom_range(0, 2) == 0);
                rand_req();
            end
            alm_valid = ($urandom_range(0, 19) == 0);
            alm_hour  = 5'($urandom_range(7, 8));
            alm_min   = 6'($urandom_range(29, 30));
            cur_hour  = 5'($urandom_range(7, 8));
            cur_min   = 6'($urandom_range(29, 30));
            cur_sec   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'd59;
            step();
        end
        rst = 1'b0; set_valid = 1'b0; alm_valid = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
